// File: rtl/fp_add_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fp_add_ctrl_pkg
// Purpose  : Shared FSM state type, exponent limits and align-count helper
//            for the floating-point adder controller.
// Revision : 1.0 - initial release
// ============================================================================
package fp_add_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ALIGN = 3'd2,
    ADD   = 3'd3,
    NORM  = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic [7:0] ALIGN_MAX = 8'd25;
  localparam logic [7:0] EXP_MAX   = 8'hFE;
  localparam logic [7:0] EXP_MIN   = 8'h01;

  // Shifting a 24-bit mantissa further than 25 places always yields zero,
  // so the distance is clamped there.
  function automatic logic [7:0] align_count(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] diff;
    diff = (a >= b) ? (a - b) : (b - a);
    return (diff > ALIGN_MAX) ? ALIGN_MAX : diff;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fp_add_ctrl_align_cnt.sv
`default_nettype none
// ============================================================================
// Module   : align_cnt
// Purpose  : 8-bit loadable down-counter with zero flag; tracks remaining
//            alignment shifts of the smaller mantissa.
// Revision : 1.0 - initial release
// ============================================================================
module align_cnt (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       dec,
  input  logic [7:0] load_val,
  output logic [7:0] count,
  output logic       zero
);

  logic [7:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= 8'd0;
    end else if (load) begin
      r_count <= load_val;
    end else if (dec && (r_count != 8'd0)) begin
      r_count <= r_count - 8'd1;
    end
  end

  assign count = r_count;
  assign zero  = (r_count == 8'd0);

endmodule
`default_nettype wire

// File: rtl/fp_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fp_add_ctrl
// Purpose  : Sequencing FSM for a floating-point adder: exponent compare,
//            mantissa alignment, add and normalisation with ovf/unf flags.
// Revision : 1.0 - initial release
// ============================================================================
module fp_add_ctrl
  import fp_add_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] exp_a,
  input  logic [7:0] exp_b,
  input  logic [7:0] exp_out,
  input  logic       sum_carry,
  input  logic       sum_msb,
  input  logic       sum_zero,
  output logic       ld_exp,
  output logic       cen_up_exp,
  output logic       cen_down_exp,
  output logic [7:0] parin_exp,
  output logic       ld_ma,
  output logic       ld_mb,
  output logic       sel_small,
  output logic       shr_small,
  output logic       ld_sum,
  output logic       shr_sum,
  output logic       shl_sum,
  output logic       busy,
  output logic       done,
  output logic       ovf,
  output logic       unf
);

  state_t     r_state;
  logic       r_sel_small;
  logic       r_ovf;
  logic       r_unf;
  logic [7:0] w_align_init;
  logic [7:0] w_exp_max;
  logic       w_sel_small;
  logic [7:0] w_cnt;
  logic       w_cnt_zero;
  logic       w_align_last;

  assign w_align_init = align_count(exp_a, exp_b);
  assign w_sel_small  = (exp_b <= exp_a);
  assign w_exp_max    = w_sel_small ? exp_a : exp_b;
  // Counter still shows the pre-decrement value, so 1 means this is the final shift.
  assign w_align_last = w_cnt_zero || (w_cnt == 8'd1);

  align_cnt u_align_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (r_state == LOAD),
    .dec      (r_state == ALIGN),
    .load_val (w_align_init),
    .count    (w_cnt),
    .zero     (w_cnt_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_sel_small <= 1'b0;
      r_ovf       <= 1'b0;
      r_unf       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state <= LOAD;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
          end
        end
        LOAD: begin
          r_sel_small <= w_sel_small;
          r_state     <= (w_align_init != 8'd0) ? ALIGN : ADD;
        end
        ALIGN: begin
          if (w_align_last) r_state <= ADD;
        end
        ADD: r_state <= NORM;
        NORM: begin
          if (sum_carry) begin
            r_state <= DONE;
            if (exp_out == EXP_MAX) r_ovf <= 1'b1;
          end else if (sum_zero || sum_msb) begin
            r_state <= DONE;
          end else if (exp_out == EXP_MIN) begin
            r_unf   <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    ld_exp       = 1'b0;
    cen_up_exp   = 1'b0;
    cen_down_exp = 1'b0;
    parin_exp    = 8'h00;
    ld_ma        = 1'b0;
    ld_mb        = 1'b0;
    sel_small    = 1'b0;
    shr_small    = 1'b0;
    ld_sum       = 1'b0;
    shr_sum      = 1'b0;
    shl_sum      = 1'b0;
    case (r_state)
      LOAD: begin
        ld_exp    = 1'b1;
        parin_exp = w_exp_max;
        ld_ma     = 1'b1;
        ld_mb     = 1'b1;
        sel_small = w_sel_small;
      end
      ALIGN: begin
        sel_small = r_sel_small;
        shr_small = 1'b1;
      end
      ADD: begin
        sel_small = r_sel_small;
        ld_sum    = 1'b1;
      end
      NORM: begin
        sel_small = r_sel_small;
        if (sum_carry) begin
          shr_sum    = 1'b1;
          cen_up_exp = 1'b1;
        end else if (sum_zero) begin
          ld_exp = 1'b1;
        end else if (!sum_msb && (exp_out != EXP_MIN)) begin
          shl_sum      = 1'b1;
          cen_down_exp = 1'b1;
        end
      end
      DONE:    sel_small = r_sel_small;
      default: ;
    endcase
  end

  assign busy = (r_state != IDLE);
  assign done = (r_state == DONE);
  assign ovf  = r_ovf;
  assign unf  = r_unf;

endmodule
`default_nettype wire

// File: tb/tb_fp_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_add_ctrl
// Purpose  : Self-checking bench for fp_add_ctrl: directed and random
//            additions compared cycle by cycle against a sequence model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fp_add_ctrl;

  typedef struct packed {
    logic       ld_exp;
    logic       cen_up;
    logic       cen_down;
    logic [7:0] parin;
    logic       ld_ma;
    logic       ld_mb;
    logic       sel;
    logic       shr_small;
    logic       ld_sum;
    logic       shr_sum;
    logic       shl_sum;
    logic       busy;
    logic       done;
    logic       ovf;
    logic       unf;
  } ctl_t;

  localparam int T_CARRY = 0;
  localparam int T_OVF   = 1;
  localparam int T_ZERO  = 2;
  localparam int T_MSB   = 3;
  localparam int T_UNF   = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] exp_a, exp_b, exp_out;
  logic       sum_carry, sum_msb, sum_zero;
  logic       ld_exp, cen_up_exp, cen_down_exp;
  logic [7:0] parin_exp;
  logic       ld_ma, ld_mb, sel_small, shr_small, ld_sum, shr_sum, shl_sum;
  logic       busy, done, ovf, unf;

  ctl_t obs;
  int   checks   = 0;
  int   failures = 0;
  logic prev_ovf = 1'b0;
  logic prev_unf = 1'b0;

  always #5 clk = ~clk;

  fp_add_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .exp_a        (exp_a),
    .exp_b        (exp_b),
    .exp_out      (exp_out),
    .sum_carry    (sum_carry),
    .sum_msb      (sum_msb),
    .sum_zero     (sum_zero),
    .ld_exp       (ld_exp),
    .cen_up_exp   (cen_up_exp),
    .cen_down_exp (cen_down_exp),
    .parin_exp    (parin_exp),
    .ld_ma        (ld_ma),
    .ld_mb        (ld_mb),
    .sel_small    (sel_small),
    .shr_small    (shr_small),
    .ld_sum       (ld_sum),
    .shr_sum      (shr_sum),
    .shl_sum      (shl_sum),
    .busy         (busy),
    .done         (done),
    .ovf          (ovf),
    .unf          (unf)
  );

  always_comb obs = {ld_exp, cen_up_exp, cen_down_exp, parin_exp, ld_ma, ld_mb,
                     sel_small, shr_small, ld_sum, shr_sum, shl_sum, busy, done, ovf, unf};

  task automatic compare(input string tag, input ctl_t exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // Settle, compare, then move to just after the next rising edge.
  task automatic check(input string tag, input ctl_t exp_v);
    #1;
    compare(tag, exp_v);
    @(posedge clk);
    #1;
  endtask

  // One complete addition: k plain left-shift cycles in NORM, then a terminal case.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int k,
                        input int term, input logic noisy_start);
    ctl_t e;
    int   n;
    logic sel;
    logic of, uf;
    sel = (b <= a);
    n   = (a > b) ? int'(a) - int'(b) : int'(b) - int'(a);
    if (n > 25) n = 25;
    of = 1'b0;
    uf = (term == T_UNF);

    exp_a = a; exp_b = b; start = 1'b1;
    sum_carry = 1'b0; sum_msb = 1'b0; sum_zero = 1'b0; exp_out = 8'h80;
    e = '0; e.ovf = prev_ovf; e.unf = prev_unf;
    check("idle_start", e);
    start = noisy_start;

    e = '0; e.busy = 1'b1; e.ld_exp = 1'b1; e.parin = (a > b) ? a : b;
    e.ld_ma = 1'b1; e.ld_mb = 1'b1; e.sel = sel;
    check("load", e);

    for (int i = 0; i < n; i++) begin
      e = '0; e.busy = 1'b1; e.sel = sel; e.shr_small = 1'b1;
      check("align", e);
    end

    e = '0; e.busy = 1'b1; e.sel = sel; e.ld_sum = 1'b1;
    check("add", e);

    for (int i = 0; i < k; i++) begin
      exp_out = 8'($urandom_range(2, 254));
      e = '0; e.busy = 1'b1; e.sel = sel; e.shl_sum = 1'b1; e.cen_down = 1'b1;
      check("norm_shl", e);
    end

    e = '0; e.busy = 1'b1; e.sel = sel;
    case (term)
      T_CARRY, T_OVF: begin
        sum_carry = 1'b1;
        sum_msb   = 1'($urandom);
        sum_zero  = 1'($urandom);
        exp_out   = (term == T_OVF) ? 8'hFE : 8'($urandom_range(1, 253));
        e.shr_sum = 1'b1; e.cen_up = 1'b1;
        of = (term == T_OVF);
      end
      T_ZERO: begin
        sum_zero = 1'b1;
        sum_msb  = 1'($urandom);
        exp_out  = 8'($urandom_range(0, 255));
        e.ld_exp = 1'b1;
      end
      T_MSB: begin
        sum_msb = 1'b1;
        exp_out = 8'($urandom_range(0, 255));
      end
      default: exp_out = 8'h01;
    endcase
    check("norm_end", e);

    start = 1'b0; sum_carry = 1'b0; sum_msb = 1'b0; sum_zero = 1'b0;
    e = '0; e.busy = 1'b1; e.sel = sel; e.done = 1'b1; e.ovf = of; e.unf = uf;
    check("done", e);

    e = '0; e.ovf = of; e.unf = uf;
    check("idle_after", e);
    prev_ovf = of;
    prev_unf = uf;
  endtask

  initial begin
    ctl_t e;
    rst = 1'b1; start = 1'b1;
    exp_a = 8'h55; exp_b = 8'h22; exp_out = 8'h80;
    sum_carry = 1'b1; sum_msb = 1'b1; sum_zero = 1'b1;
    #2;
    compare("in_reset", '0);
    @(posedge clk); #1;
    compare("reset_held_edge", '0);
    start = 1'b0; sum_carry = 1'b0; sum_msb = 1'b0; sum_zero = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;

    run_op(8'h82, 8'h80, 0, T_MSB,   1'b0);
    run_op(8'h7F, 8'h7F, 0, T_CARRY, 1'b0);
    run_op(8'h10, 8'hF0, 0, T_MSB,   1'b1);
    run_op(8'h40, 8'h41, 3, T_MSB,   1'b0);
    run_op(8'h40, 8'h41, 0, T_UNF,   1'b0);
    run_op(8'h05, 8'h05, 0, T_OVF,   1'b1);
    run_op(8'hA0, 8'h90, 1, T_ZERO,  1'b0);
    run_op(8'h00, 8'hFF, 0, T_CARRY, 1'b0);
    run_op(8'h20, 8'h39, 2, T_UNF,   1'b1);

    // Reset landing between edges in the middle of a long alignment.
    exp_a = 8'h10; exp_b = 8'hF0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    e = '0; e.busy = 1'b1; e.shr_small = 1'b0; e.sel = 1'b0; e.shr_small = 1'b1;
    compare("align_before_rst", e);
    #2;
    rst = 1'b1;
    #1;
    compare("rst_mid_align", '0);
    @(posedge clk); #1;
    compare("rst_mid_held", '0);
    rst = 1'b0;
    prev_ovf = 1'b0;
    prev_unf = 1'b0;
    run_op(8'h82, 8'h80, 1, T_MSB, 1'b0);

    for (int i = 0; i < 30; i++) begin
      logic [7:0] a, b;
      a = 8'($urandom);
      b = ($urandom_range(0, 1) == 1) ? 8'(a + 8'($urandom_range(0, 6))) : 8'($urandom);
      run_op(a, b, $urandom_range(0, 3), $urandom_range(0, 4), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fp_add_ctrl.md
FP_ADD_CTRL -- requirements
Module: fp_add_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, single clock, all state on rising edge.
REQ-002 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port start, input, 1, request one addition; sampled in IDLE only.
REQ-004 SHALL have ports exp_a and exp_b, input, 8 each, operand biased exponents, stable from start until done.
REQ-005 SHALL have port exp_out, input, 8, current value of the exponent up/down counter.
REQ-006 SHALL have ports sum_carry, sum_msb and sum_zero, input, 1 each: mantissa sum carry-out, sum bit 23, and sum all-zero.
REQ-007 SHALL have ports ld_exp, cen_up_exp and cen_down_exp, output, 1 each, exponent counter controls, at most one high per cycle.
REQ-008 SHALL have port parin_exp, output, 8, exponent counter load value.
REQ-009 SHALL have ports ld_ma, ld_mb, sel_small, shr_small, ld_sum, shr_sum and shl_sum, output, 1 each, mantissa datapath controls; sel_small=1 means B is the smaller operand.
REQ-010 SHALL have ports busy and done, output, 1 each; done is a one-cycle pulse.
REQ-011 SHALL have ports ovf and unf, output, 1 each, sticky result flags.

Function
REQ-012 SHALL implement FSM states IDLE, LOAD, ALIGN, ADD, NORM, DONE; busy=1 in every state except IDLE.
REQ-013 IDLE: start=1 -> LOAD next cycle and clear ovf/unf; start is ignored in all other states.
REQ-014 LOAD, one cycle: ld_exp=1, parin_exp=max(exp_a,exp_b), ld_ma=ld_mb=1, sel_small=(exp_b<=exp_a); load align count with min(|exp_a-exp_b|,25).
REQ-015 LOAD exit: next state ALIGN if align count nonzero, else ADD.
REQ-016 ALIGN: assert shr_small and decrement align count each cycle; exactly N cycles for count N, then ADD.
REQ-017 sel_small SHALL be held constant from LOAD until DONE.
REQ-018 ADD, one cycle: ld_sum=1, then NORM.
REQ-019 NORM priority 1, sum_carry=1: shr_sum=1 and cen_up_exp=1, then DONE; if exp_out==8'hFE, also set ovf.
REQ-020 NORM priority 2, sum_zero=1: ld_exp=1, parin_exp=8'h00, then DONE.
REQ-021 NORM priority 3, sum_msb=1: no controls asserted, then DONE.
REQ-022 NORM priority 4, exp_out==8'h01: set unf, no shift, then DONE.
REQ-023 NORM otherwise: shl_sum=1 and cen_down_exp=1, remain in NORM, re-evaluate next cycle.
REQ-024 DONE: done=1 for one cycle, then IDLE; ovf/unf hold until the next accepted start.
REQ-025 Control outputs SHALL be combinational from state and inputs, with no glitch-dependent use; flags and count SHALL be registered.
REQ-026 Exponent difference arithmetic SHALL be unsigned 8-bit with no wrap; equal exponents give count 0.

Reset
REQ-027 rst=1 SHALL immediately force IDLE, align count 0, and ovf=unf=done=busy=0 regardless of clk, including mid-operation.
REQ-028 While in reset, all control outputs SHALL be 0 and parin_exp SHALL be 8'h00.
REQ-029 After reset deassertion, the first start SHALL be accepted on the next rising edge.

Structure
REQ-030 A shared package SHALL hold the state enum, ALIGN_MAX=25, EXP_MAX=8'hFE and EXP_MIN=8'h01.
REQ-031 The align counter SHALL be a sub-module align_cnt (8-bit, load/decrement, zero flag); the FSM stays in fp_add_ctrl.

Verification
REQ-032 exp_a=8'h82, exp_b=8'h80, start@T0, sum_msb=1: LOAD@T1 (parin_exp=8'h82, sel_small=1), shr_small@T2-T3, ld_sum@T4, NORM@T5, done@T6.
REQ-033 exp_a=exp_b=8'h7F: ALIGN skipped, ld_sum one cycle after LOAD; sum_carry=1 gives shr_sum+cen_up_exp, then done.
REQ-034 exp_a=8'h10, exp_b=8'hF0: count saturates at 25, shr_small exactly 25 cycles, sel_small=0.
REQ-035 NORM with sum_msb=0 for 3 cycles: three shl_sum+cen_down_exp pulses; with exp_out=8'h01 instead, unf=1 and no shift.
REQ-036 NORM with sum_carry=1 and exp_out=8'hFE -> ovf=1; sum_zero=1 -> ld_exp with parin_exp=8'h00.
REQ-037 rst asserted mid-ALIGN between edges: outputs drop to 0 immediately; start during busy is ignored.
